// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in parallel-out deserializer.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_e;

endpackage

// File: rtl/sipo_shreg.sv
// Frame shift register and bit counter; sin enters the MSB so the first bit lands in bit 0.
module sipo_shreg #(
    parameter int FRAME_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 sin,
    output logic                 frame_done,
    output logic [FRAME_LEN-1:0] frame_next
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    logic [FRAME_LEN-1:0] shreg_r;
    logic [CNT_W-1:0]     count_r;

    // Word as it will look after this edge's shift, and whether this edge ends the frame
    always_comb begin
        frame_next = {sin, shreg_r[FRAME_LEN-1:1]};
        frame_done = shift_en && (count_r == CNT_W'(FRAME_LEN - 1));
    end

    // Shift and count; the counter wraps to zero on the completing bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= '0;
            count_r <= '0;
        end else if (clear) begin
            shreg_r <= '0;
            count_r <= '0;
        end else if (shift_en) begin
            shreg_r <= frame_next;
            count_r <= frame_done ? '0 : (count_r + CNT_W'(1));
        end else begin
            shreg_r <= shreg_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Deserializer top: FSM, output holding register, valid/ready handshake and sticky flags.
// Optional even-parity trailer bit enabled by macro SIPO_PARITY_CHECK_EN.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             shift_en,
    input  logic             clear,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SIPO_PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    sipo_state_e          state_r;
    sipo_state_e          state_next_s;
    logic                 frame_done_s;
    logic [FRAME_LEN-1:0] frame_next_s;
    logic [WIDTH-1:0]     pout_r;
    logic                 pout_valid_r;
    logic                 overrun_r;
    logic                 accept_s;

    sipo_shreg #(
        .FRAME_LEN (FRAME_LEN)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .shift_en   (shift_en),
        .sin        (sin),
        .frame_done (frame_done_s),
        .frame_next (frame_next_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: first bit leaves IDLE, completing bit returns to it
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = (shift_en && !frame_done_s) ? SHIFT : IDLE;
                SHIFT:   state_next_s = frame_done_s ? IDLE : SHIFT;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // A completed word is taken when the holding register is empty or being drained this edge
    always_comb begin
        accept_s = !pout_valid_r || pout_ready;
    end

    // Holding register, valid flag and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pout_r       <= '0;
            pout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (clear) begin
            pout_r       <= '0;
            pout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (frame_done_s && accept_s) begin
            pout_r       <= frame_next_s[WIDTH-1:0];
            pout_valid_r <= 1'b1;
            overrun_r    <= overrun_r;
        end else if (frame_done_s) begin
            pout_r       <= pout_r;
            pout_valid_r <= pout_valid_r;
            overrun_r    <= 1'b1;
        end else if (pout_valid_r && pout_ready) begin
            pout_r       <= pout_r;
            pout_valid_r <= 1'b0;
            overrun_r    <= overrun_r;
        end else begin
            pout_r       <= pout_r;
            pout_valid_r <= pout_valid_r;
            overrun_r    <= overrun_r;
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    logic parity_err_r;

    // Even parity over data plus trailer: any set result is an error
    function automatic logic frame_parity_bad(input logic [FRAME_LEN-1:0] frame);
        return ^frame;
    endfunction

    // Sticky parity flag, evaluated on every completed frame even if the word is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_r <= 1'b0;
        end else if (clear) begin
            parity_err_r <= 1'b0;
        end else if (frame_done_s && frame_parity_bad(frame_next_s)) begin
            parity_err_r <= 1'b1;
        end else begin
            parity_err_r <= parity_err_r;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign pout       = pout_r;
    assign pout_valid = pout_valid_r;
    assign overrun    = overrun_r;
    assign busy       = (state_r == SHIFT);

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of data bits per frame (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 SHALL have port sin, input, 1 bit, serial data from the upstream PISO, LSB first.
REQ-005 SHALL have port shift_en, input, 1 bit, which qualifies sin; one bit is captured per edge while it is high.
REQ-006 SHALL have port clear, input, 1 bit, a synchronous abort of the frame in progress and of the output state.
REQ-007 SHALL have port pout, output, WIDTH bits, the assembled parallel word.
REQ-008 SHALL have port pout_valid, output, 1 bit; high means pout holds an unconsumed word.
REQ-009 SHALL have port pout_ready, input, 1 bit; the consumer accepts pout on an edge where pout_valid and pout_ready are both high.
REQ-010 SHALL have port busy, output, 1 bit, high while a frame is partially received.
REQ-011 SHALL have port overrun, output, 1 bit, a sticky flag for a dropped word.
REQ-012 SHALL have port parity_err, output, 1 bit, a sticky parity-failure flag (see Configuration).

Function
REQ-013 SHALL use an FSM with two states. IDLE: bit count is 0. SHIFT: 0 < count < FRAME_LEN.
REQ-014 SHALL go IDLE->SHIFT on the first shift_en edge, and SHIFT->IDLE on the edge that captures the bit making count reach FRAME_LEN.
REQ-015 SHALL shift right on each shift_en edge: sin enters the MSB, so the first bit received ends up in pout[0].
REQ-016 SHALL hold the shift register, count and state unchanged while shift_en is low; there is no timeout.
REQ-017 SHALL, on the edge that captures the last data bit, load pout and set pout_valid; zero-cycle latency from that edge.
REQ-018 SHALL drive busy high exactly while the state is SHIFT.
REQ-019 SHALL clear pout_valid on an edge where pout_valid and pout_ready are both high, unless a new word completes on the same edge.
REQ-020 SHALL, when a new word completes on the same edge as acceptance, load the new word and keep pout_valid=1, without setting overrun.
REQ-021 SHALL, when a word completes while pout_valid=1 and pout_ready=0, drop the new word, keep the old pout, and set overrun.
REQ-022 SHALL hold overrun high until clear or reset.
REQ-023 SHALL, when clear is high, on that edge force IDLE, count 0, shift register 0, pout 0, pout_valid 0, overrun 0 and parity_err 0; clear has priority over shift_en and pout_ready.
REQ-024 SHALL accept back-to-back frames with no gap cycle: a shift_en bit on the edge after completion starts the next frame.

Reset
REQ-025 SHALL, while rst_n=0, immediately force IDLE, count 0, shift register 0, pout 0, pout_valid 0, busy 0, overrun 0 and parity_err 0.
REQ-026 SHALL discard any partial frame when reset is asserted mid-frame; the first shift_en after release starts a new frame.

Configuration
REQ-027 SHALL, with macro SIPO_PARITY_CHECK_EN defined, use FRAME_LEN = WIDTH+1: WIDTH data bits followed by one even-parity bit.
REQ-028 SHALL, with SIPO_PARITY_CHECK_EN defined, set parity_err on completion if XOR(data, parity) != 0; the word is still delivered per REQ-017..021.
REQ-029 SHALL, without SIPO_PARITY_CHECK_EN, use FRAME_LEN = WIDTH and tie parity_err to 0.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, SHIFT) and the default WIDTH constant in shared package sipo_pkg.
REQ-031 SHALL put the shift register and bit counter in one sub-module, sipo_shreg; the FSM, output holding register, handshake and flags stay in sipo_deser.

Verification
REQ-032 SHALL test the basic frame: WIDTH=4, no parity, sin 1,0,1,0 over 4 shift_en cycles -> pout=4'b0101, pout_valid=1 after the 4th edge, busy=1 only during bits 1-3.
REQ-033 SHALL test the hold: pout_ready=0 for 5 cycles after the REQ-032 frame -> pout_valid and pout stay at 4'b0101; then pout_ready=1 for one cycle -> pout_valid=0.
REQ-034 SHALL test overrun: send 4'b0101, keep pout_ready=0, send 4'b1100 -> pout stays 4'b0101 and overrun=1; pulse clear -> pout_valid=0 and overrun=0.
REQ-035 SHALL test simultaneous events: pout_ready=1 on the edge completing the second frame 4'b0011 -> pout=4'b0011, pout_valid=1, overrun=0.
REQ-036 SHALL test reset mid-frame: after 2 bits assert rst_n=0, then send a full 4'b1001 frame -> pout=4'b1001 with no residue from the aborted bits.
REQ-037 SHALL, with SIPO_PARITY_CHECK_EN, send data 4'b0111 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err stays 0.
